// File: rtl/rgb_fade_pwm_core.sv
// Triangle fade generator driving a free-running PWM comparator. pwm_out lags pwm_value by one clk.
// No flow control: every output is valid every cycle and nothing can stall it.
`timescale 1ns/1ps
module rgb_fade_pwm_core #(
   parameter int PWM_INTERVAL  = 1200,
   parameter int STEP_INTERVAL = 10000,
   parameter int STEP_MAX      = 200
) (
   input  logic                                clk,
   input  logic                                rst_n,
   output logic [$clog2(PWM_INTERVAL+1)-1:0]   pwm_value,
   output logic                                pwm_out,
   output logic                                fade_dir,
   output logic                                ramp_done
);

   localparam int STEP_VAL = PWM_INTERVAL / STEP_MAX;
   localparam int VW       = $clog2(PWM_INTERVAL + 1);
   localparam int SW       = $clog2(STEP_INTERVAL + 1);
   localparam int RW       = $clog2(STEP_MAX + 1);

   logic [SW-1:0] step_cnt_q, step_cnt_d;
   logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [VW-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [VW-1:0] pwm_value_q, pwm_value_d;
   logic          fade_dir_q, fade_dir_d;
   logic          pwm_out_q, pwm_out_d;
   logic          ramp_done_q, ramp_done_d;
   logic          step_edge;
   logic          ramp_end;

   always_comb begin
      step_edge   = (step_cnt_q == SW'(STEP_INTERVAL - 1));
      ramp_end    = step_edge && (ramp_cnt_q == RW'(STEP_MAX - 1));

      step_cnt_d  = step_edge ? '0 : step_cnt_q + SW'(1);
      ramp_cnt_d  = ramp_cnt_q;
      pwm_value_d = pwm_value_q;
      fade_dir_d  = fade_dir_q;
      ramp_done_d = 1'b0;

      if (step_edge) begin
         // The ramp length is fixed by step count, so the end points are exact and cannot wrap.
         if (fade_dir_q) begin
            pwm_value_d = pwm_value_q + VW'(STEP_VAL);
         end else begin
            pwm_value_d = pwm_value_q - VW'(STEP_VAL);
         end
         if (ramp_end) begin
            ramp_cnt_d  = '0;
            fade_dir_d  = ~fade_dir_q;
            ramp_done_d = 1'b1;
         end else begin
            ramp_cnt_d  = ramp_cnt_q + RW'(1);
         end
      end

      pwm_cnt_d = (pwm_cnt_q == VW'(PWM_INTERVAL - 1)) ? '0 : pwm_cnt_q + VW'(1);
      // Compared against the live duty value; a mid-period change applies on the next cycle.
      pwm_out_d = (pwm_cnt_q < pwm_value_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt_q  <= '0;
         ramp_cnt_q  <= '0;
         pwm_cnt_q   <= '0;
         pwm_value_q <= '0;
         fade_dir_q  <= 1'b1;
         pwm_out_q   <= 1'b0;
         ramp_done_q <= 1'b0;
      end else begin
         step_cnt_q  <= step_cnt_d;
         ramp_cnt_q  <= ramp_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         pwm_value_q <= pwm_value_d;
         fade_dir_q  <= fade_dir_d;
         pwm_out_q   <= pwm_out_d;
         ramp_done_q <= ramp_done_d;
      end
   end

   assign pwm_value = pwm_value_q;
   assign pwm_out   = pwm_out_q;
   assign fade_dir  = fade_dir_q;
   assign ramp_done = ramp_done_q;

endmodule

// File: tb/tb_rgb_fade_pwm_core.sv
// Randomized bench for rgb_fade_pwm_core: reference outputs derived from elapsed clocks since reset.
`timescale 1ns/1ps
module tb_rgb_fade_pwm_core;

   localparam int PI = 8;
   localparam int SI = 4;
   localparam int SM = 4;
   localparam int SV = PI / SM;
   localparam int VW = $clog2(PI + 1);

   typedef struct {
      int v;
      int o;
      int d;
      int r;
   } exp_t;

   logic          clk;
   logic          clk_en;
   logic          rst_n;
   logic [VW-1:0] pwm_value;
   logic          pwm_out;
   logic          fade_dir;
   logic          ramp_done;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   t        = 0;
   bit   in_rst   = 1'b1;
   exp_t q[$];

   rgb_fade_pwm_core #(
      .PWM_INTERVAL (PI),
      .STEP_INTERVAL(SI),
      .STEP_MAX     (SM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_value(pwm_value),
      .pwm_out  (pwm_out),
      .fade_dir (fade_dir),
      .ramp_done(ramp_done)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // Triangle wave: position within a 2*SM step period decides the level.
   function automatic int val_at(int tt);
      int steps = tt / SI;
      int pos   = steps % (2 * SM);
      return (pos <= SM) ? pos * SV : (2 * SM - pos) * SV;
   endfunction

   function automatic exp_t exp_at(int tt);
      exp_t e;
      int steps = tt / SI;
      e.v = val_at(tt);
      e.d = (((steps / SM) % 2) == 0) ? 1 : 0;
      e.r = (tt > 0 && (tt % SI) == 0 && (steps % SM) == 0) ? 1 : 0;
      e.o = (tt == 0) ? 0 : ((((tt - 1) % PI) < val_at(tt - 1)) ? 1 : 0);
      return e;
   endfunction

   function automatic exp_t rst_exp();
      exp_t e;
      e.v = 0; e.o = 0; e.d = 1; e.r = 0;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t (t=%0d): got %0d, expected %0d", name, $time, t, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!in_rst) t++;
      q.push_back(in_rst ? rst_exp() : exp_at(t));
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("pwm_value", int'(pwm_value), e.v);
         check("pwm_out",   int'(pwm_out),   e.o);
         check("fade_dir",  int'(fade_dir),  e.d);
         check("ramp_done", int'(ramp_done), e.r);
      end
   end

   task automatic async_stopped_reset();
      @(negedge clk);
      #1 clk_en = 1'b0;
      #3 rst_n  = 1'b0;
      #2;
      check("async_rst_value", int'(pwm_value), 0);
      check("async_rst_out",   int'(pwm_out),   0);
      check("async_rst_dir",   int'(fade_dir),  1);
      check("async_rst_done",  int'(ramp_done), 0);
      #5 rst_n = 1'b1;
      t      = 0;
      in_rst = 1'b0;
      #2 clk_en = 1'b1;
   endtask

   task automatic running_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      in_rst = 1'b1;
      t      = 0;
      repeat ($urandom_range(1, 3)) step();
      @(negedge clk);
      #1 rst_n = 1'b1;
      in_rst = 1'b0;
   endtask

   initial begin
      clk_en = 1'b1;
      rst_n  = 1'b0;
      repeat (3) step();
      @(negedge clk);
      #1 rst_n = 1'b1;
      in_rst = 1'b0;
      t      = 0;
      // First stretch long enough to cover a full up/down period from reset.
      repeat (40) step();
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(1, 90)) step();
         case ($urandom_range(0, 2))
            0:       async_stopped_reset();
            1:       running_reset();
            default: ;
         endcase
      end
      repeat (70) step();
      @(negedge clk);
      #2;
      check("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end of stimulus, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
